// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// ALU operation codes and the instruction classes the FSM sequences on.
package cu_pkg;

  localparam logic [2:0] ST_IF   = 3'b000;
  localparam logic [2:0] ST_ID   = 3'b001;
  localparam logic [2:0] ST_EXE  = 3'b010;
  localparam logic [2:0] ST_MEM  = 3'b011;
  localparam logic [2:0] ST_WB   = 3'b100;
  localparam logic [2:0] ST_HALT = 3'b111;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_OR   = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000011;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b110000;
  localparam logic [5:0] OP_SW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b101;

  // Instruction groups that take distinct paths through the FSM.
  typedef enum logic [3:0] {
    CL_R, CL_ADDI, CL_ORI, CL_LW, CL_SW, CL_BEQ, CL_J, CL_HALT, CL_ILL
  } instr_class_t;

endpackage

// File: rtl/op_decode.sv
// Opcode decode: instruction class plus the static datapath controls that
// depend only on the opcode, not on the FSM state.
module op_decode
  import cu_pkg::*;
#(
  parameter int W_OP = 6
) (
  input  logic [W_OP-1:0] i_opcode,
  output instr_class_t    o_cls,
  output logic            o_reg_dst,
  output logic            o_alu_src_b,
  output logic            o_ext_sel,
  output logic [2:0]      o_alu_op
);

  always_comb begin
    o_cls       = CL_ILL;
    o_reg_dst   = 1'b0;
    o_alu_src_b = 1'b0;
    o_ext_sel   = 1'b1;
    o_alu_op    = ALU_ADD;
    case (i_opcode)
      W_OP'(OP_ADD):  begin o_cls = CL_R; o_reg_dst = 1'b1; end
      W_OP'(OP_SUB):  begin o_cls = CL_R; o_reg_dst = 1'b1; o_alu_op = ALU_SUB; end
      W_OP'(OP_OR):   begin o_cls = CL_R; o_reg_dst = 1'b1; o_alu_op = ALU_OR; end
      W_OP'(OP_ADDI): begin o_cls = CL_ADDI; o_alu_src_b = 1'b1; end
      W_OP'(OP_ORI):  begin
        o_cls = CL_ORI; o_alu_src_b = 1'b1; o_ext_sel = 1'b0; o_alu_op = ALU_OR;
      end
      W_OP'(OP_LW):   begin o_cls = CL_LW; o_alu_src_b = 1'b1; end
      W_OP'(OP_SW):   begin o_cls = CL_SW; o_alu_src_b = 1'b1; end
      W_OP'(OP_BEQ):  begin o_cls = CL_BEQ; o_alu_op = ALU_SUB; end
      W_OP'(OP_J):    o_cls = CL_J;
      W_OP'(OP_HALT): o_cls = CL_HALT;
      default:        o_cls = CL_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB/HALT). All outputs are
// combinational from the registered state and the IR opcode.
module control_unit
  import cu_pkg::*;
#(
  parameter int W_OP = 6
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [W_OP-1:0] opcode,
  input  logic            zero,
  output logic            PCWre,
  output logic [1:0]      PCSrc,
  output logic            IRWre,
  output logic            RegWre,
  output logic            RegDst,
  output logic            ALUSrcB,
  output logic            ExtSel,
  output logic [2:0]      ALUOp,
  output logic            mRD,
  output logic            mWR,
  output logic            DBDataSrc,
  output logic [2:0]      state
);

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  instr_class_t w_cls;
  logic [2:0]   w_alu_op;
  logic         w_run;
  logic         w_short;

  op_decode #(.W_OP(W_OP)) u_dec (
    .i_opcode    (opcode),
    .o_cls       (w_cls),
    .o_reg_dst   (RegDst),
    .o_alu_src_b (ALUSrcB),
    .o_ext_sel   (ExtSel),
    .o_alu_op    (w_alu_op)
  );

  // j and illegal opcodes both retire in ID.
  assign w_short = (w_cls == CL_J) || (w_cls == CL_ILL);

  always_comb begin
    w_next = ST_IF;
    case (r_state)
      ST_IF:   w_next = ST_ID;
      ST_ID:   w_next = w_short ? ST_IF : (w_cls == CL_HALT) ? ST_HALT : ST_EXE;
      ST_EXE:  w_next = (w_cls == CL_BEQ) ? ST_IF :
                        ((w_cls == CL_LW) || (w_cls == CL_SW)) ? ST_MEM : ST_WB;
      ST_MEM:  w_next = (w_cls == CL_SW) ? ST_IF : ST_WB;
      ST_WB:   w_next = ST_IF;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= ST_IF;
    else       r_state <= w_next;
  end

  // Write enables are forced low for the whole reset cycle, even mid-instruction.
  assign w_run = !Reset;

  assign state  = r_state;
  assign IRWre  = w_run && (r_state == ST_IF);
  assign PCWre  = w_run && (((r_state == ST_ID) && w_short) ||
                            ((r_state == ST_EXE) && (w_cls == CL_BEQ)) ||
                            ((r_state == ST_MEM) && (w_cls == CL_SW)) ||
                            (r_state == ST_WB));
  assign PCSrc  = ((r_state == ST_ID) && (w_cls == CL_J)) ? 2'b10 :
                  ((r_state == ST_EXE) && (w_cls == CL_BEQ) && zero) ? 2'b01 : 2'b00;
  assign RegWre    = w_run && (r_state == ST_WB);
  assign mRD       = (r_state == ST_MEM) && (w_cls == CL_LW);
  assign mWR       = w_run && (r_state == ST_MEM) && (w_cls == CL_SW);
  assign DBDataSrc = (r_state == ST_WB) && (w_cls == CL_LW);
  assign ALUOp     = ((r_state == ST_IF) || (r_state == ST_HALT)) ? ALU_ADD : w_alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction walks, then a random
// instruction stream, all checked cycle by cycle against a CPI-table model.
module tb_control_unit;

  localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_OR = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b000011, T_ORI = 6'b010000, T_LW = 6'b110000;
  localparam logic [5:0] T_SW = 6'b110001, T_BEQ = 6'b110100, T_J = 6'b111000;
  localparam logic [5:0] T_HALT = 6'b111111;
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4, S_HALT = 3'd7;

  logic       CLK = 1'b0;
  logic       Reset, zero;
  logic [5:0] opcode;
  logic       PCWre, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp, state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  control_unit #(.W_OP(6)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
    .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {T_ADD, T_SUB, T_OR, T_ADDI, T_ORI, T_LW, T_SW, T_BEQ, T_J, T_HALT};
  endfunction

  // Cycles per instruction, straight from the CPI table.
  function automatic int cpi(input logic [5:0] op);
    if (!is_legal(op) || op == T_J) return 2;
    if (op == T_BEQ) return 3;
    if (op == T_LW) return 5;
    return 4;
  endfunction

  function automatic logic [2:0] exp_state(input logic [5:0] op, input int k);
    if (op == T_HALT) return (k == 0) ? S_IF : (k == 1) ? S_ID : S_HALT;
    case (k)
      0:       return S_IF;
      1:       return S_ID;
      2:       return S_EXE;
      3:       return (op == T_LW || op == T_SW) ? S_MEM : S_WB;
      default: return S_WB;
    endcase
  endfunction

  // zmode: -1 random zero each cycle, 0/1 forced. rst_at: cycle index to assert Reset (-1 none).
  task automatic run_instr(input logic [5:0] op, input int zmode, input int rst_at);
    int         n;
    logic [2:0] s;
    logic [2:0] aop;
    logic [1:0] psrc;
    string      nm;
    nm = $sformatf("op%06b", op);
    opcode = op;
    n = (op == T_HALT) ? 12 : cpi(op);
    for (int k = 0; k < n; k++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (k == rst_at) Reset = 1'b1;
      @(negedge CLK);
      s = exp_state(op, k);
      check($sformatf("%s c%0d state", nm, k), 32'(state), 32'(s));
      if (k == rst_at) begin
        check($sformatf("%s c%0d rst_en", nm, k),
              {28'd0, PCWre, IRWre, RegWre, mWR}, 32'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        return;
      end
      aop = 3'b000;
      if (s != S_IF && s != S_HALT) begin
        if (op == T_SUB || op == T_BEQ) aop = 3'b001;
        else if (op == T_OR || op == T_ORI) aop = 3'b101;
      end
      psrc = 2'b00;
      if (op == T_J && k == 1) psrc = 2'b10;
      else if (op == T_BEQ && k == 2 && zero) psrc = 2'b01;
      check($sformatf("%s c%0d IRWre", nm, k), 32'(IRWre), 32'(k == 0));
      check($sformatf("%s c%0d PCWre", nm, k), 32'(PCWre),
            32'(op != T_HALT && k == cpi(op) - 1));
      check($sformatf("%s c%0d PCSrc", nm, k), 32'(PCSrc), 32'(psrc));
      check($sformatf("%s c%0d ALUOp", nm, k), 32'(ALUOp), 32'(aop));
      check($sformatf("%s c%0d mem", nm, k), {30'd0, mRD, mWR},
            {30'd0, op == T_LW && s == S_MEM, op == T_SW && s == S_MEM});
      check($sformatf("%s c%0d wb", nm, k), {30'd0, RegWre, DBDataSrc},
            {30'd0, s == S_WB, op == T_LW && s == S_WB});
      check($sformatf("%s c%0d static", nm, k), {29'd0, RegDst, ALUSrcB, ExtSel},
            {29'd0, op inside {T_ADD, T_SUB, T_OR}, op inside {T_ADDI, T_ORI, T_LW, T_SW},
             op != T_ORI});
      @(posedge CLK); #1;
    end
  endtask

  task automatic reset_pulse(input logic [2:0] cur_state);
    Reset = 1'b1;
    @(negedge CLK);
    check("pulse state", 32'(state), 32'(cur_state));
    check("pulse en", {28'd0, PCWre, IRWre, RegWre, mWR}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] legal_ops [10];
    legal_ops = '{T_ADD, T_SUB, T_OR, T_ADDI, T_ORI, T_LW, T_SW, T_BEQ, T_J, T_HALT};
    Reset = 1'b1; zero = 1'b0; opcode = T_ADD;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("reset state", 32'(state), 32'(S_IF));
    check("reset en", {28'd0, PCWre, IRWre, RegWre, mWR}, 32'd0);
    @(posedge CLK); #1;
    Reset = 1'b0;

    run_instr(T_LW, -1, -1);
    run_instr(T_BEQ, 1, -1);
    run_instr(T_BEQ, 0, -1);
    run_instr(T_J, -1, -1);
    run_instr(6'b101010, -1, -1);
    run_instr(T_ORI, -1, -1);
    run_instr(T_ADD, -1, -1);
    run_instr(T_SUB, -1, -1);
    run_instr(T_OR, -1, -1);
    run_instr(T_ADDI, -1, -1);
    run_instr(T_SW, -1, 3);
    run_instr(T_SW, -1, -1);
    run_instr(T_HALT, -1, -1);
    reset_pulse(S_HALT);
    run_instr(T_LW, -1, 2);
    run_instr(T_BEQ, -1, -1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 6'($urandom_range(0, 63));
        for (int t = 0; t < 64 && is_legal(op); t++) op = 6'($urandom_range(0, 63));
        if (is_legal(op)) op = 6'b101010;
      end else begin
        op = legal_ops[$urandom_range(0, 9)];
      end
      run_instr(op, -1, -1);
      if (op == T_HALT) reset_pulse(S_HALT);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter W_OP, default 6, giving the opcode field width.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port opcode, input, W_OP bits: IR[31:26], stable from the cycle after IF.
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port PCWre, output, 1 bit: PC write enable.
REQ-007 SHALL have port PCSrc, output, 2 bits: 00 = PC+4, 01 = branch target, 10 = jump target.
REQ-008 SHALL have port IRWre, output, 1 bit: IR write enable.
REQ-009 SHALL have port RegWre, output, 1 bit: register-file write enable.
REQ-010 SHALL have port RegDst, output, 1 bit: 1 = rd, 0 = rt.
REQ-011 SHALL have port ALUSrcB, output, 1 bit: 1 = extended immediate, 0 = register B.
REQ-012 SHALL have port ExtSel, output, 1 bit: 1 = sign-extend, 0 = zero-extend.
REQ-013 SHALL have port ALUOp, output, 3 bits: 000 = add, 001 = sub, 101 = or.
REQ-014 SHALL have port mRD, output, 1 bit: data-memory read enable.
REQ-015 SHALL have port mWR, output, 1 bit: data-memory write enable.
REQ-016 SHALL have port DBDataSrc, output, 1 bit: 1 = memory data, 0 = ALU result.
REQ-017 SHALL have port state, output, 3 bits: current state, for debug.

Function
REQ-018 SHALL decode these opcodes: add 000000, sub 000001, or 000010, addi 000011, ori 010000, lw 110000, sw 110001, beq 110100, j 111000, halt 111111. All others are illegal.
REQ-019 SHALL implement states IF = 000, ID = 001, EXE = 010, MEM = 011, WB = 100, HALT = 111.
REQ-020 SHALL make these transitions:
- IF -> ID.
- ID -> IF for j and illegal opcodes.
- ID -> HALT for halt.
- ID -> EXE otherwise.
- EXE -> IF for beq.
- EXE -> MEM for lw and sw.
- EXE -> WB otherwise.
- MEM -> IF for sw.
- MEM -> WB for lw.
- WB -> IF.
- HALT -> HALT until Reset.
REQ-021 SHALL assert IRWre only in IF.
REQ-022 SHALL assert PCWre exactly once per instruction, in the terminal cycle: ID for j/illegal, EXE for beq, MEM for sw, WB otherwise. PCWre SHALL never be asserted in HALT.
REQ-023 SHALL drive PCSrc as:
- 10 in ID for j.
- 01 in EXE for beq when zero = 1.
- 00 in all other cycles.
REQ-024 SHALL sample zero only in the EXE cycle of beq; zero in other cycles SHALL have no effect.
REQ-025 SHALL drive ALUOp as:
- 001 for sub and beq.
- 101 for or and ori.
- 000 otherwise, including idle states.
REQ-026 SHALL set ALUSrcB = 1 for addi, ori, lw and sw; ExtSel = 0 only for ori; RegDst = 1 only for add, sub and or.
REQ-027 SHALL assert mRD only in MEM for lw, and mWR only in MEM for sw.
REQ-028 SHALL assert RegWre only in WB; DBDataSrc = 1 only in WB for lw.
REQ-029 SHALL produce all outputs combinationally from the registered state and opcode, so they are valid in the same cycle as the state.
REQ-030 SHALL give each instruction class a fixed CPI: j/illegal 2, beq 3, R-type/addi/ori 4, sw 4, lw 5.
REQ-031 SHALL treat an illegal opcode as a nop: PC advances by 4 and there are no register or memory writes.

Reset
REQ-032 SHALL, on Reset = 1 at a clock edge, load state = IF regardless of the current state, including HALT and mid-instruction.
REQ-033 SHALL hold all write enables (PCWre, IRWre, RegWre, mWR) at 0 while Reset is high.
REQ-034 SHALL, in the first cycle after Reset deasserts, be in IF with IRWre = 1.

Structure
REQ-035 SHALL place the state encodings, opcode constants and ALUOp constants (ADD 000, SUB 001, OR 101) in the shared package cu_pkg.
REQ-036 SHALL place the opcode-to-static-controls decode (RegDst, ALUSrcB, ExtSel, ALUOp class) in one sub-module, op_decode; the FSM and the per-state enables SHALL stay in control_unit.

Verification
REQ-037 SHALL cover lw: opcode 110000 after reset -> states IF, ID, EXE, MEM, WB; mRD = 1 in MEM; RegWre = 1 and DBDataSrc = 1 in WB; PCWre only in WB.
REQ-038 SHALL cover beq taken and not taken: opcode 110100 with zero = 1 -> PCSrc = 01 and PCWre = 1 in EXE, then IF; with zero = 0 -> PCSrc = 00.
REQ-039 SHALL cover j and illegal: 111000 -> PCSrc = 10 and PCWre = 1 in ID, then IF; 101010 -> PCSrc = 00, PCWre = 1 in ID, and no RegWre, mRD or mWR at any point.
REQ-040 SHALL cover ori: 010000 -> ALUOp = 101, ALUSrcB = 1, ExtSel = 0, RegDst = 0, RegWre in WB.
REQ-041 SHALL cover halt: 111111 -> HALT held for 10 cycles with PCWre = 0; Reset pulse -> IF on the next cycle.
REQ-042 SHALL cover mid-instruction reset: Reset asserted in MEM of sw -> mWR = 0 that cycle, state = IF next cycle.
